mul_flag_unit: RTL and testbench
================================

Name: mul_flag_unit

Overview:
- Downstream consumer of the multiplier's flag outputs (mv, mn, mu, mi).
- Holds the multiplier fields of the arithmetic status register (ASTAT) and the sticky status register (STKY).
- Aligns flag capture to the multiplier execute cycle and supplies condition bits to the program sequencer (PS).
- Gives PS system-register read/write/bit-op access and raises a masked interrupt pulse when a sticky bit first sets.

Parameters:
RF_DATASIZE, 16, width of the system-register data path (minimum 4)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
ps_mul_en  input  1  multiplier enable, issue cycle (same signal the multiplier receives)
ps_mul_cls  input  2  multiplier op class, issue cycle
ps_mul_sc  input  2  multiplier subclass, issue cycle
mul_ps_mv  input  1  overflow flag from multiplier, valid in execute cycle
mul_ps_mn  input  1  sign flag from multiplier, valid in execute cycle
mul_ps_mu  input  1  underflow flag from multiplier, valid in execute cycle
mul_ps_mi  input  1  invalid flag from multiplier, valid in issue cycle
ps_sreg_sel  input  2  00 none, 01 ASTAT, 10 STKY, 11 none
ps_sreg_op  input  2  00 write, 01 bit-set, 10 bit-clear, 11 bit-toggle
ps_sreg_we  input  1  perform ps_sreg_op on the selected register
ps_sreg_wdata  input  RF_DATASIZE  write data or bit mask
ps_irq_mask  input  3  enable per sticky bit {MIS, MUS, MOS}
sreg_rdata  output  RF_DATASIZE  selected register value, combinational, zero when sel is none
ps_cond_mv  output  1  ASTAT.MV
ps_cond_mn  output  1  ASTAT.MN
ps_cond_mu  output  1  ASTAT.MU
ps_cond_mi  output  1  ASTAT.MI
mul_irq  output  1  one-cycle interrupt pulse

Behaviour:
- Bit map:
  - ASTAT[0]=MN, [1]=MV, [2]=MU, [3]=MI.
  - STKY[0]=MOS, [1]=MUS, [2]=MIS.
  - All other bits read 0; writes to them are ignored.
- Reset: ASTAT=0, STKY=0, ex_en=0, mi_pend=0, mul_irq=0. Every output reads 0.
- Issue-stage registers:
  - ex_en <= ps_mul_en every cycle.
  - ex_xfer <= (ps_mul_cls==00 && ps_mul_sc!=11), loaded only when ps_mul_en=1. This marks MR-transfer ops.
  - mi_pend <= ps_mul_en & mul_ps_mi.
- Execute update, at the edge where ex_en=1:
  - If ex_xfer=0: MV<=mv, MN<=mn, MU<=mu, MI<=mi_pend.
  - If ex_xfer=1: MV and MN hold; MU<=mu; MI<=mi_pend.
  - Sticky: MOS|=MV_new, MUS|=MU_new, MIS|=MI_new.
- When ex_en=0, ASTAT and STKY change only through PS access.
- Latency: a flag becomes visible on ps_cond_* and sreg_rdata one cycle after the multiplier execute cycle, i.e. two edges after ps_mul_en is sampled high.
- PS access (ps_sreg_we=1, sel 01/10), with mask m=wdata:
  - write: reg<=m.
  - set: reg|=m.
  - clear: reg&=~m.
  - toggle: reg^=m.
- Simultaneous PS access and execute update:
  - ASTAT: the PS result is applied first, then the execute update overrides the multiplier-driven bits (MN/MV/MU/MI). Hardware wins.
  - STKY: the PS result is applied first, then the execute update ORs in its set bits. A hardware set beats a PS clear in the same cycle.
- Interrupt: mul_irq <= |(ps_irq_mask & STKY_next & ~STKY).
  - One cycle only, registered.
  - A sticky bit already set produces no further pulse until software clears it.
  - A PS write/set that raises a sticky bit also pulses.
- Back-to-back multiplier ops: each execute cycle updates independently. No flag accumulation in ASTAT.
- Reset mid-operation: everything clears asynchronously. A pending mi_pend is lost. No pulse is generated on reset release.

Decomposition:
- Shared package (mul_flag_pkg): ASTAT/STKY bit-index constants, sreg_sel and sreg_op encodings, and the MR-transfer class/subclass constants (CLS_XFER=00, SC_SAT=11).
- One sub-module, sreg_bitop: combinational (reg, mask, op) -> new value. Used for both ASTAT and STKY.

Test Plan:
- Reset asserted mid-run with ASTAT=0xF, STKY=0x7 -> all outputs 0 immediately; mul_irq stays 0 after release.
- ps_mul_en=1, cls=01, then mv=1, mn=1 in execute -> the following cycle ASTAT=0x0003, STKY=0x0001; with ps_irq_mask=001, exactly one mul_irq pulse. A second overflow gives no pulse.
- ps_mul_en=1, cls=00, sc=01 (MR transfer) with mv=1, mn=1 presented -> ASTAT MV/MN unchanged from prior 0; STKY unchanged.
- mul_ps_mi=1 in issue cycle -> MI=1 and MIS=1 one cycle after execute; ps_cond_mi=1; sreg_rdata with sel=10 reads 0x0004.
- Same cycle: PS bit-clear STKY mask 0x0001 while execute has mv=1 -> STKY.MOS remains 1. Next cycle a clear with no execute -> MOS=0.
- Bit-op coverage on ASTAT=0x0005: toggle 0x000F -> 0x000A; set 0x00F0 -> 0x000A (upper bits ignored); write 0xFFFF -> 0x000F.

Source files
------------

// File: rtl/mul_flag_unit_pkg.sv
// Shared definitions for the multiplier flag unit: register bit map,
// system-register select/op encodings and MR-transfer decode constants.
package mul_flag_pkg;

  // ASTAT multiplier field bit positions
  localparam int unsigned ASTAT_MN = 0;
  localparam int unsigned ASTAT_MV = 1;
  localparam int unsigned ASTAT_MU = 2;
  localparam int unsigned ASTAT_MI = 3;
  localparam int unsigned ASTAT_W  = 4;

  // STKY multiplier field bit positions
  localparam int unsigned STKY_MOS = 0;
  localparam int unsigned STKY_MUS = 1;
  localparam int unsigned STKY_MIS = 2;
  localparam int unsigned STKY_W   = 3;

  typedef enum logic [1:0] {
    SREG_NONE    = 2'b00,
    SREG_ASTAT   = 2'b01,
    SREG_STKY    = 2'b10,
    SREG_NONE_HI = 2'b11
  } sreg_sel_e;

  typedef enum logic [1:0] {
    SREG_WRITE = 2'b00,
    SREG_SET   = 2'b01,
    SREG_CLR   = 2'b10,
    SREG_TGL   = 2'b11
  } sreg_op_e;

  // MR-transfer ops: class 00 with any subclass except the saturate form
  localparam logic [1:0] CLS_XFER = 2'b00;
  localparam logic [1:0] SC_SAT   = 2'b11;

endpackage

// File: rtl/mul_flag_unit_if.sv
// Bus between the program sequencer / multiplier and the flag unit.
interface mul_flag_unit_if #(
  parameter int unsigned RF_DATASIZE = 16
);
  logic                   ps_mul_en;
  logic [1:0]             ps_mul_cls;
  logic [1:0]             ps_mul_sc;
  logic                   mul_ps_mv;
  logic                   mul_ps_mn;
  logic                   mul_ps_mu;
  logic                   mul_ps_mi;
  logic [1:0]             ps_sreg_sel;
  logic [1:0]             ps_sreg_op;
  logic                   ps_sreg_we;
  logic [RF_DATASIZE-1:0] ps_sreg_wdata;
  logic [2:0]             ps_irq_mask;
  logic [RF_DATASIZE-1:0] sreg_rdata;
  logic                   ps_cond_mv;
  logic                   ps_cond_mn;
  logic                   ps_cond_mu;
  logic                   ps_cond_mi;
  logic                   mul_irq;

  modport master (
    output ps_mul_en, ps_mul_cls, ps_mul_sc,
    output mul_ps_mv, mul_ps_mn, mul_ps_mu, mul_ps_mi,
    output ps_sreg_sel, ps_sreg_op, ps_sreg_we, ps_sreg_wdata, ps_irq_mask,
    input  sreg_rdata, ps_cond_mv, ps_cond_mn, ps_cond_mu, ps_cond_mi, mul_irq
  );

  modport slave (
    input  ps_mul_en, ps_mul_cls, ps_mul_sc,
    input  mul_ps_mv, mul_ps_mn, mul_ps_mu, mul_ps_mi,
    input  ps_sreg_sel, ps_sreg_op, ps_sreg_we, ps_sreg_wdata, ps_irq_mask,
    output sreg_rdata, ps_cond_mv, ps_cond_mn, ps_cond_mu, ps_cond_mi, mul_irq
  );
endinterface

// File: rtl/mul_flag_unit_sreg_bitop.sv
// Combinational system-register bit operation: write, set, clear, toggle.
module sreg_bitop
  import mul_flag_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] cur,
  input  logic [W-1:0] mask,
  input  sreg_op_e     op,
  output logic [W-1:0] result
);

  // Apply the selected operation of mask onto the current value
  always_comb begin
    result = cur;
    case (op)
      SREG_WRITE: result = mask;
      SREG_SET:   result = cur | mask;
      SREG_CLR:   result = cur & ~mask;
      SREG_TGL:   result = cur ^ mask;
      default:    result = cur;
    endcase
  end

endmodule

// File: rtl/mul_flag_unit.sv
// Multiplier flag unit: ASTAT/STKY multiplier fields, execute-aligned flag
// capture, PS system-register access and masked sticky-set interrupt.
module mul_flag_unit
  import mul_flag_pkg::*;
#(
  parameter int unsigned RF_DATASIZE = 16
) (
  input  logic            clk,
  input  logic            reset,
  mul_flag_unit_if.slave  bus
);

  logic                   ex_en;
  logic                   ex_xfer;
  logic                   mi_pend;
  logic                   irq_q;
  logic [ASTAT_W-1:0]     astat;
  logic [ASTAT_W-1:0]     astat_nxt;
  logic [STKY_W-1:0]      stky;
  logic [STKY_W-1:0]      stky_nxt;
  logic [STKY_W-1:0]      stky_hw;
  logic [RF_DATASIZE-1:0] astat_ext;
  logic [RF_DATASIZE-1:0] stky_ext;
  logic [RF_DATASIZE-1:0] astat_bo;
  logic [RF_DATASIZE-1:0] stky_bo;
  logic                   unused_bo;
  sreg_sel_e              sel;
  sreg_op_e               op;

  assign sel = sreg_sel_e'(bus.ps_sreg_sel);
  assign op  = sreg_op_e'(bus.ps_sreg_op);

  // Zero-extend the narrow registers onto the system-register data path
  always_comb begin
    astat_ext = '0;
    stky_ext  = '0;
    astat_ext[ASTAT_W-1:0] = astat;
    stky_ext[STKY_W-1:0]   = stky;
  end

  sreg_bitop #(.W(RF_DATASIZE)) u_astat_bitop (
    .cur    (astat_ext),
    .mask   (bus.ps_sreg_wdata),
    .op     (op),
    .result (astat_bo)
  );

  sreg_bitop #(.W(RF_DATASIZE)) u_stky_bitop (
    .cur    (stky_ext),
    .mask   (bus.ps_sreg_wdata),
    .op     (op),
    .result (stky_bo)
  );

  // Bits above the register fields are discarded on write
  assign unused_bo = &{1'b0, astat_bo[RF_DATASIZE-1:STKY_W], stky_bo[RF_DATASIZE-1:STKY_W]};

  // Next register state: PS access first, execute update layered on top.
  // Sticky sets come only from bits the multiplier actually drove this cycle,
  // so a held MV/MN during an MR transfer never re-sets MOS.
  always_comb begin
    astat_nxt = astat;
    stky_nxt  = stky;
    stky_hw   = '0;
    if (bus.ps_sreg_we && sel == SREG_ASTAT) astat_nxt = astat_bo[ASTAT_W-1:0];
    if (bus.ps_sreg_we && sel == SREG_STKY)  stky_nxt  = stky_bo[STKY_W-1:0];
    if (ex_en) begin
      if (!ex_xfer) begin
        astat_nxt[ASTAT_MV] = bus.mul_ps_mv;
        astat_nxt[ASTAT_MN] = bus.mul_ps_mn;
        stky_hw[STKY_MOS]   = bus.mul_ps_mv;
      end
      astat_nxt[ASTAT_MU] = bus.mul_ps_mu;
      astat_nxt[ASTAT_MI] = mi_pend;
      stky_hw[STKY_MUS]   = bus.mul_ps_mu;
      stky_hw[STKY_MIS]   = mi_pend;
    end
    stky_nxt = stky_nxt | stky_hw;
  end

  // Issue-stage pipeline, status registers and interrupt pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_en   <= 1'b0;
      ex_xfer <= 1'b0;
      mi_pend <= 1'b0;
      astat   <= '0;
      stky    <= '0;
      irq_q   <= 1'b0;
    end else begin
      ex_en   <= bus.ps_mul_en;
      if (bus.ps_mul_en) ex_xfer <= (bus.ps_mul_cls == CLS_XFER) && (bus.ps_mul_sc != SC_SAT);
      mi_pend <= bus.ps_mul_en & bus.mul_ps_mi;
      astat   <= astat_nxt;
      stky    <= stky_nxt;
      irq_q   <= |(bus.ps_irq_mask & stky_nxt & ~stky);
    end
  end

  // Register read mux; unselected encodings read zero
  always_comb begin
    bus.sreg_rdata = '0;
    case (sel)
      SREG_ASTAT: bus.sreg_rdata = astat_ext;
      SREG_STKY:  bus.sreg_rdata = stky_ext;
      default:    bus.sreg_rdata = '0;
    endcase
  end

  assign bus.ps_cond_mv = astat[ASTAT_MV];
  assign bus.ps_cond_mn = astat[ASTAT_MN];
  assign bus.ps_cond_mu = astat[ASTAT_MU];
  assign bus.ps_cond_mi = astat[ASTAT_MI];
  assign bus.mul_irq    = irq_q;

endmodule

// File: tb/tb_mul_flag_unit.sv
// Directed self-checking bench for mul_flag_unit.
module tb_mul_flag_unit;
  import mul_flag_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  mul_flag_unit_if #(.RF_DATASIZE(16)) bus ();

  mul_flag_unit #(.RF_DATASIZE(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ps_mul_en     = 1'b0;
    bus.ps_mul_cls    = 2'b01;
    bus.ps_mul_sc     = 2'b00;
    bus.mul_ps_mv     = 1'b0;
    bus.mul_ps_mn     = 1'b0;
    bus.mul_ps_mu     = 1'b0;
    bus.mul_ps_mi     = 1'b0;
    bus.ps_sreg_sel   = 2'b00;
    bus.ps_sreg_op    = 2'b00;
    bus.ps_sreg_we    = 1'b0;
    bus.ps_sreg_wdata = '0;
    bus.ps_irq_mask   = 3'b000;
  endtask

  task automatic check_reg(input string tag, input logic [1:0] sel, input logic [15:0] exp);
    bus.ps_sreg_sel = sel;
    #1;
    check(tag, {16'h0, bus.sreg_rdata}, {16'h0, exp});
  endtask

  task automatic sreg(input logic [1:0] sel, input logic [1:0] op, input logic [15:0] d);
    bus.ps_sreg_sel   = sel;
    bus.ps_sreg_op    = op;
    bus.ps_sreg_wdata = d;
    bus.ps_sreg_we    = 1'b1;
    step();
    bus.ps_sreg_we    = 1'b0;
  endtask

  // Issue cycle followed by execute cycle; returns just after the update edge
  task automatic mul_op(input logic [1:0] cls, input logic [1:0] sc, input logic mi,
                        input logic mv, input logic mn, input logic mu);
    bus.ps_mul_en  = 1'b1;
    bus.ps_mul_cls = cls;
    bus.ps_mul_sc  = sc;
    bus.mul_ps_mi  = mi;
    step();
    bus.ps_mul_en  = 1'b0;
    bus.mul_ps_mi  = 1'b0;
    bus.mul_ps_mv  = mv;
    bus.mul_ps_mn  = mn;
    bus.mul_ps_mu  = mu;
    step();
    bus.mul_ps_mv  = 1'b0;
    bus.mul_ps_mn  = 1'b0;
    bus.mul_ps_mu  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    idle();
    #12;
    // Reset state
    check("rst_irq", {31'h0, bus.mul_irq}, 32'h0);
    check("rst_cond", {28'h0, bus.ps_cond_mi, bus.ps_cond_mu, bus.ps_cond_mv, bus.ps_cond_mn}, 32'h0);
    check_reg("rst_astat", SREG_ASTAT, 16'h0000);
    check_reg("rst_stky", SREG_STKY, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    step();

    // Normal op with overflow + sign, MOS interrupt enabled
    bus.ps_irq_mask = 3'b001;
    mul_op(2'b01, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    check("ovf_irq", {31'h0, bus.mul_irq}, 32'h1);
    check("ovf_cond", {30'h0, bus.ps_cond_mv, bus.ps_cond_mn}, 32'h3);
    check_reg("ovf_astat", SREG_ASTAT, 16'h0003);
    check_reg("ovf_stky", SREG_STKY, 16'h0001);
    step();
    check("ovf_irq_one", {31'h0, bus.mul_irq}, 32'h0);
    check_reg("sel_none0", SREG_NONE, 16'h0000);
    check_reg("sel_none3", SREG_NONE_HI, 16'h0000);

    // Second overflow: no pulse, ASTAT reflects only this op
    mul_op(2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    check("ovf2_irq", {31'h0, bus.mul_irq}, 32'h0);
    check_reg("ovf2_astat", SREG_ASTAT, 16'h0002);
    check_reg("ovf2_stky", SREG_STKY, 16'h0001);
    step();
    check("ovf2_irq_after", {31'h0, bus.mul_irq}, 32'h0);

    // MR transfer: MV/MN held, STKY unaffected
    sreg(SREG_ASTAT, SREG_WRITE, 16'h0000);
    sreg(SREG_STKY, SREG_WRITE, 16'h0000);
    mul_op(CLS_XFER, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0);
    check("xfer_irq", {31'h0, bus.mul_irq}, 32'h0);
    check_reg("xfer_astat", SREG_ASTAT, 16'h0000);
    check_reg("xfer_stky", SREG_STKY, 16'h0000);

    // Invalid flag from the issue cycle
    bus.ps_irq_mask = 3'b100;
    mul_op(2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    check("mi_irq", {31'h0, bus.mul_irq}, 32'h1);
    check("mi_cond", {31'h0, bus.ps_cond_mi}, 32'h1);
    check_reg("mi_astat", SREG_ASTAT, 16'h0008);
    check_reg("mi_stky", SREG_STKY, 16'h0004);

    // Hardware sticky set beats PS clear in the same cycle
    bus.ps_irq_mask = 3'b000;
    sreg(SREG_STKY, SREG_WRITE, 16'h0001);
    bus.ps_mul_en  = 1'b1;
    bus.ps_mul_cls = 2'b01;
    step();
    bus.ps_mul_en     = 1'b0;
    bus.mul_ps_mv     = 1'b1;
    bus.ps_sreg_sel   = SREG_STKY;
    bus.ps_sreg_op    = SREG_CLR;
    bus.ps_sreg_wdata = 16'h0001;
    bus.ps_sreg_we    = 1'b1;
    step();
    bus.ps_sreg_we    = 1'b0;
    bus.mul_ps_mv     = 1'b0;
    check_reg("clr_race_stky", SREG_STKY, 16'h0001);
    check_reg("clr_race_astat", SREG_ASTAT, 16'h0002);
    sreg(SREG_STKY, SREG_CLR, 16'h0001);
    check_reg("clr_stky", SREG_STKY, 16'h0000);

    // PS set raising a sticky bit pulses the interrupt
    bus.ps_irq_mask = 3'b001;
    sreg(SREG_STKY, SREG_SET, 16'h0001);
    check("ps_set_irq", {31'h0, bus.mul_irq}, 32'h1);
    step();
    check("ps_set_irq_one", {31'h0, bus.mul_irq}, 32'h0);

    // ASTAT bit operations
    sreg(SREG_ASTAT, SREG_WRITE, 16'h0005);
    check_reg("bo_write5", SREG_ASTAT, 16'h0005);
    sreg(SREG_ASTAT, SREG_TGL, 16'h000F);
    check_reg("bo_tgl", SREG_ASTAT, 16'h000A);
    sreg(SREG_ASTAT, SREG_SET, 16'h00F0);
    check_reg("bo_set_hi", SREG_ASTAT, 16'h000A);
    sreg(SREG_ASTAT, SREG_WRITE, 16'hFFFF);
    check_reg("bo_write_all", SREG_ASTAT, 16'h000F);
    sreg(SREG_STKY, SREG_WRITE, 16'hFFF8);
    check_reg("stky_hi_ignored", SREG_STKY, 16'h0000);

    // ASTAT: PS set applied first, execute overrides driven bits
    bus.ps_mul_en  = 1'b1;
    bus.ps_mul_cls = 2'b01;
    step();
    bus.ps_mul_en     = 1'b0;
    bus.mul_ps_mv     = 1'b1;
    bus.ps_sreg_sel   = SREG_ASTAT;
    bus.ps_sreg_op    = SREG_SET;
    bus.ps_sreg_wdata = 16'h000F;
    bus.ps_sreg_we    = 1'b1;
    step();
    bus.ps_sreg_we    = 1'b0;
    bus.mul_ps_mv     = 1'b0;
    check_reg("hw_wins_astat", SREG_ASTAT, 16'h0002);

    // MR transfer with simultaneous PS write: MV/MN keep PS value
    bus.ps_mul_en  = 1'b1;
    bus.ps_mul_cls = CLS_XFER;
    bus.ps_mul_sc  = 2'b01;
    step();
    bus.ps_mul_en     = 1'b0;
    bus.ps_sreg_sel   = SREG_ASTAT;
    bus.ps_sreg_op    = SREG_WRITE;
    bus.ps_sreg_wdata = 16'h000F;
    bus.ps_sreg_we    = 1'b1;
    step();
    bus.ps_sreg_we    = 1'b0;
    check_reg("xfer_ps_astat", SREG_ASTAT, 16'h0003);
    check("xfer_ps_cond", {28'h0, bus.ps_cond_mi, bus.ps_cond_mu, bus.ps_cond_mv, bus.ps_cond_mn}, 32'h3);

    // Reset mid-run with everything set and an invalid flag pending
    bus.ps_irq_mask = 3'b111;
    bus.ps_mul_sc   = 2'b00;
    sreg(SREG_ASTAT, SREG_WRITE, 16'hFFFF);
    sreg(SREG_STKY, SREG_WRITE, 16'h0007);
    check_reg("pre_rst_stky", SREG_STKY, 16'h0007);
    @(posedge clk);
    #1;
    bus.ps_mul_en  = 1'b1;
    bus.ps_mul_cls = 2'b01;
    bus.mul_ps_mi  = 1'b1;
    step();
    bus.ps_mul_en  = 1'b0;
    bus.mul_ps_mi  = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_cond", {28'h0, bus.ps_cond_mi, bus.ps_cond_mu, bus.ps_cond_mv, bus.ps_cond_mn}, 32'h0);
    check("mid_rst_irq", {31'h0, bus.mul_irq}, 32'h0);
    check_reg("mid_rst_astat", SREG_ASTAT, 16'h0000);
    check_reg("mid_rst_stky", SREG_STKY, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    step();
    check("post_rst_irq", {31'h0, bus.mul_irq}, 32'h0);
    check_reg("post_rst_stky", SREG_STKY, 16'h0000);
    check_reg("post_rst_astat", SREG_ASTAT, 16'h0000);
    step();
    check("post_rst_irq2", {31'h0, bus.mul_irq}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
